// File: rtl/nibble_serial_adder.sv
// Multi-precision adder that reuses a single 4-bit ripple slice, one nibble per cycle, LSB first.
// Optional feature macro: ADD_SUB_EN (adds sub/ovf ports for two's-complement subtraction).
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_partial;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
`ifdef ADD_SUB_EN
    logic             r_ovf;
`endif

    logic [CNT_W+1:0] w_bit_base;
    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic [4:0]       w_slice;
    logic [WIDTH-1:0] w_merged;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic             w_ovf;

    // Operand conditioning at accept time: subtraction is a + ~b + 1.
    always_comb begin
        w_b_eff   = b;
        w_cin_eff = cin;
`ifdef ADD_SUB_EN
        if (sub) begin
            w_b_eff   = ~b;
            w_cin_eff = 1'b1;
        end else begin
            w_b_eff   = b;
            w_cin_eff = cin;
        end
`endif
    end

    // The single 4-bit slice and the partial result with the current nibble merged in.
    always_comb begin
        w_bit_base = {r_cnt, 2'b00};
        w_nib_a    = r_a[w_bit_base +: 4];
        w_nib_b    = r_b[w_bit_base +: 4];
        w_slice    = {1'b0, w_nib_a} + {1'b0, w_nib_b} + {4'b0000, r_carry};
        w_merged   = r_partial;
        w_merged[w_bit_base +: 4] = w_slice[3:0];
        w_ovf      = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_merged[WIDTH-1] != r_a[WIDTH-1]);
    end

    // Control FSM, datapath registers and registered status/result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_carry   <= 1'b0;
            r_a       <= {WIDTH{1'b0}};
            r_b       <= {WIDTH{1'b0}};
            r_partial <= {WIDTH{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sum     <= {WIDTH{1'b0}};
            r_cout    <= 1'b0;
`ifdef ADD_SUB_EN
            r_ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_eff;
                        r_carry <= w_cin_eff;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_busy  <= 1'b1;
                        r_state <= ST_ADD;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_ADD: begin
                    r_partial <= w_merged;
                    r_carry   <= w_slice[4];
                    if (r_cnt == LAST_CNT) begin
                        // Result becomes visible only here, so sum/cout never show partials.
                        r_sum   <= w_merged;
                        r_cout  <= w_slice[4];
`ifdef ADD_SUB_EN
                        r_ovf   <= w_ovf;
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= ST_ADD;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef ADD_SUB_EN
    assign ovf  = r_ovf;
`else
    logic w_unused;
    assign w_unused = w_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADD_SUB_EN
    logic             sub;
    logic             ovf;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [WIDTH-1:0] ref_sum;
    logic             ref_cout;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
`ifdef ADD_SUB_EN
        .sub     (sub),
        .ovf     (ovf),
`endif
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge (cycle 0). Ends at the done cycle if chain=1, else one cycle later.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                          input logic isub, input bit chain, input bit poke);
        logic [16:0] t;
        logic [15:0] esum;
        logic        ecout;
        logic        eovf;
        int          sa;
        int          sb;
        int          sr;
        a = ia;
        b = ib;
        cin = icin;
`ifdef ADD_SUB_EN
        sub = isub;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom_range(0, 1));
        for (int k = 1; k <= NIB; k++) begin
            check("busy_in_op", 32'(busy), 32'd1);
            check("done_in_op", 32'(done), 32'd0);
            check("sum_hold", 32'(sum), 32'(ref_sum));
            check("cout_hold", 32'(cout), 32'(ref_cout));
            if (poke && k == 2) begin
                start = 1'b1;
                a = 16'h1111;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        sa = ia[15] ? int'(ia) - 65536 : int'(ia);
        sb = ib[15] ? int'(ib) - 65536 : int'(ib);
        if (isub) begin
            esum  = ia - ib;
            ecout = (ia >= ib);
            sr    = sa - sb;
        end else begin
            t     = {1'b0, ia} + {1'b0, ib} + {16'd0, icin};
            esum  = t[15:0];
            ecout = t[16];
            sr    = sa + sb + int'(icin);
        end
        eovf = (sr > 32767) || (sr < -32768);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("sum_result", 32'(sum), 32'(esum));
        check("cout_result", 32'(cout), 32'(ecout));
`ifdef ADD_SUB_EN
        check("ovf_result", 32'(ovf), 32'(eovf));
`endif
        ref_sum  = esum;
        ref_cout = ecout;
        if (!chain) begin
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_not_busy", 32'(busy), 32'd0);
            check("sum_after_done", 32'(sum), 32'(ref_sum));
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rs;
        bit          rch;
        reset_n = 1'b0;
        start = 1'b0;
        a = 16'h0000;
        b = 16'h0000;
        cin = 1'b0;
`ifdef ADD_SUB_EN
        sub = 1'b0;
`endif
        ref_sum = 16'h0000;
        ref_cout = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        // Start during busy is ignored; then a back-to-back restart in the done cycle.
        run_op(16'h00F0, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset asserted mid-operation.
        a = 16'hABCD;
        b = 16'h1234;
        cin = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_abort_sum", 32'(sum), 32'h3333);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ref_sum = 16'h0000;
        ref_cout = 1'b0;
        for (int k = 0; k < NIB + 2; k++) begin
            @(negedge clk);
            check("post_abort_done", 32'(done), 32'd0);
            check("post_abort_sum", 32'(sum), 32'd0);
        end

`ifdef ADD_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 24; n++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rc  = 1'($urandom_range(0, 1));
            rch = 1'($urandom_range(0, 1));
`ifdef ADD_SUB_EN
            rs  = 1'($urandom_range(0, 1));
`else
            rs  = 1'b0;
`endif
            run_op(ra, rb, rc, rs, rch, 1'b0);
        end
        @(negedge clk);
        check("final_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
